// File: rtl/aip_prefix_sum_slave_if.sv
// AIP slave port bundle: enable, strobes, config code and both data directions.
interface aip_prefix_sum_slave_if #(
    parameter int DATA_WORD = 32
);
    logic                 i_en;
    logic [4:0]           i_config;
    logic                 i_read;
    logic                 i_write;
    logic                 i_start;
    logic [DATA_WORD-1:0] i_data_in;
    logic [DATA_WORD-1:0] o_data_out;
    logic                 o_int;

    modport master (
        output i_en, i_config, i_read, i_write, i_start, i_data_in,
        input  o_data_out, o_int
    );

    modport slave (
        input  i_en, i_config, i_read, i_write, i_start, i_data_in,
        output o_data_out, o_int
    );
endinterface

// File: rtl/aip_prefix_sum_slave.sv
// AIP slave that buffers input words and, on start, writes their running sums
// to an output buffer, then raises a level interrupt until cleared.
module aip_prefix_sum_slave #(
    parameter int DATA_WORD = 32,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_a,
    aip_prefix_sum_slave_if.slave bus
);
    localparam int LEN_W = ADDR_W + 1;

    localparam logic [4:0] CFG_MEM_IN  = 5'h00;
    localparam logic [4:0] CFG_MEM_OUT = 5'h01;
    localparam logic [4:0] CFG_CONF    = 5'h02;
    localparam logic [4:0] CFG_STATUS  = 5'h03;
    localparam logic [4:0] CFG_ID      = 5'h1E;
    localparam logic [4:0] CFG_CTRL    = 5'h1F;

    localparam logic [31:0] ID_VALUE = 32'hA1B0_0001;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [ADDR_W-1:0]    idx;
    logic [LEN_W-1:0]     len;
    logic [DATA_WORD-1:0] acc;
    logic                 done;
    logic                 err;
    logic                 irq;
    logic [DATA_WORD-1:0] data_out;

    logic [DATA_WORD-1:0] in_mem  [DEPTH];
    logic [DATA_WORD-1:0] out_mem [DEPTH];

    logic                 busy;
    logic                 mem_in_we;
    logic                 run_step;
    logic                 last_word;
    logic [DATA_WORD-1:0] acc_next;
    logic [DATA_WORD-1:0] rd_data;

    // Zero or oversize lengths fall back to a full-buffer run.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] raw);
        if (raw == '0 || raw > LEN_W'(DEPTH))
            return LEN_W'(DEPTH);
        return raw;
    endfunction

    assign busy      = (state != IDLE);
    assign mem_in_we = i_rst_a && bus.i_en && bus.i_write && !busy
                       && (bus.i_config == CFG_MEM_IN);
    assign run_step  = i_rst_a && bus.i_en && (state == RUN);
    assign acc_next  = acc + in_mem[idx];
    assign last_word = ({1'b0, idx} == (len - LEN_W'(1)));

    always_comb begin
        rd_data = '0;
        case (bus.i_config)
            CFG_MEM_OUT: rd_data = out_mem[rd_ptr];
            CFG_STATUS:  rd_data = DATA_WORD'({busy, done, err});
            CFG_ID:      rd_data = DATA_WORD'(ID_VALUE);
            default:     rd_data = '0;
        endcase
    end

    // Buffers carry no reset so their contents survive a reset.
    always_ff @(posedge i_clk) begin
        if (mem_in_we)
            in_mem[wr_ptr] <= bus.i_data_in;
        if (run_step)
            out_mem[idx] <= acc_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_a) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            idx      <= '0;
            acc      <= '0;
            len      <= LEN_W'(DEPTH);
            done     <= 1'b0;
            err      <= 1'b0;
            irq      <= 1'b0;
            data_out <= '0;
        end else if (bus.i_en) begin
            if (bus.i_read) begin
                data_out <= rd_data;
                if (bus.i_config == CFG_MEM_OUT)
                    rd_ptr <= rd_ptr + ADDR_W'(1);
            end

            if (bus.i_write) begin
                if (busy) begin
                    if (bus.i_config == CFG_MEM_IN || bus.i_config == CFG_CONF
                        || bus.i_config == CFG_CTRL)
                        err <= 1'b1;
                end else begin
                    case (bus.i_config)
                        CFG_MEM_IN: wr_ptr <= wr_ptr + ADDR_W'(1);
                        CFG_CONF:   len    <= clamp_len(bus.i_data_in[ADDR_W:0]);
                        CFG_CTRL: begin
                            if (bus.i_data_in[0]) begin
                                done <= 1'b0;
                                irq  <= 1'b0;
                            end
                            if (bus.i_data_in[1]) begin
                                err    <= 1'b0;
                                wr_ptr <= '0;
                                rd_ptr <= '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            // Start while busy is ignored; in IDLE it also re-arms a finished run.
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        state  <= RUN;
                        idx    <= '0;
                        acc    <= '0;
                        rd_ptr <= '0;
                        done   <= 1'b0;
                        irq    <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    idx <= idx + ADDR_W'(1);
                    if (last_word)
                        state <= DONE;
                end
                DONE: begin
                    done   <= 1'b1;
                    irq    <= 1'b1;
                    wr_ptr <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_data_out = data_out;
    assign bus.o_int      = irq;
endmodule

// File: doc/aip_prefix_sum_slave.md
Name: aip_prefix_sum_slave

Overview:
- AIP slave IP core that attaches to one master SoC controller slave port (s0/s1/s2).
- Takes the port's datain, config, read, write and start strobes.
- Returns dataout and a level interrupt.
- Buffers up to DEPTH input words. On start it computes running (prefix) sums into an output buffer, then raises its interrupt for the Nios master to collect the results.

Parameters:
- DATA_WORD, 32, width of AIP data bus and of every buffered word/accumulator.
- DEPTH, 16, number of entries in each of the input and output buffers (power of two).
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- i_clk  input  1  system clock; everything sampled on rising edge.
- i_rst_a  input  1  reset, synchronous, active-low.
- i_en  input  1  block enable; when low, all AIP accesses and start are ignored and state holds.
- i_config  input  5  AIP config code selecting target of read/write.
- i_read  input  1  AIP read strobe, one cycle per word.
- i_write  input  1  AIP write strobe, one cycle per word.
- i_start  input  1  start pulse.
- i_data_in  input  DATA_WORD  AIP write data.
- o_data_out  output  DATA_WORD  AIP read data, registered.
- o_int  output  1  done interrupt, level, held until cleared.

Behaviour:
- Reset (i_rst_a low at clock edge): state IDLE; wr_ptr, rd_ptr, idx, acc = 0; LEN = DEPTH; done, err, o_int = 0; o_data_out = 0. Buffer contents are not cleared.
- Config codes:
  - 5'h00 MEM_IN, write: in_mem[wr_ptr] <= i_data_in; wr_ptr++ (wraps DEPTH-1 -> 0).
  - 5'h01 MEM_OUT, read: o_data_out <= out_mem[rd_ptr] one cycle after the strobe; rd_ptr++ (wraps).
  - 5'h02 CONF, write: LEN <= i_data_in[ADDR_W:0]. Value 0 or > DEPTH is stored as DEPTH.
  - 5'h03 STATUS, read: o_data_out <= {zeros, busy, done, err} at bits [2:0], 1-cycle latency.
  - 5'h1E ID, read: o_data_out <= 32'hA1B0_0001 (zero-extended/truncated to DATA_WORD).
  - 5'h1F CTRL, write: i_data_in[0]=1 clears done and o_int; i_data_in[1]=1 clears err and zeroes wr_ptr/rd_ptr.
- Unused codes: writes ignored; reads return 0.
- o_data_out holds its last value when no read occurs.
- Same-cycle read and write: both performed independently.
- FSM:
  - IDLE: i_start & i_en -> RUN. On entry idx = 0, acc = 0, rd_ptr = 0, done = 0, o_int = 0.
  - RUN: each cycle acc_next = acc + in_mem[idx] (modulo 2^DATA_WORD, carry discarded); out_mem[idx] <= acc_next; idx++. After the word at idx = LEN-1 -> DONE.
  - DONE: one cycle; done <= 1, o_int <= 1, wr_ptr <= 0; -> IDLE.
- Latency: start sampled at edge 0; RUN occupies edges 1..LEN; o_int is high after edge LEN+1. Example: LEN = 4 gives o_int high after edge 5.
- busy = (state != IDLE).
- While busy:
  - MEM_IN, CONF and CTRL writes are dropped and set err = 1.
  - i_start is ignored (no restart, no err).
  - MEM_OUT and STATUS reads remain legal.
  - MEM_OUT reads return current out_mem contents, which may be partial.
- i_start while done = 1 in IDLE: accepted; clears done/o_int and recomputes.
- Reset asserted mid-RUN: returns to IDLE next edge; out_mem is left partially written.
- i_en low mid-RUN: FSM stalls, idx/acc hold; resumes when i_en returns high.

Test Plan:
- Reset, then ID read -> o_data_out = 32'hA1B0_0001 one cycle after i_read; STATUS read = 0.
- CONF = 4; MEM_IN writes 1, 2, 3, 4; start -> o_int high exactly 5 edges after start; MEM_OUT reads return 1, 3, 6, 10; STATUS = 3'b010.
- Overflow: LEN = 2, inputs 32'hFFFF_FFFF, 32'h0000_0002 -> outputs 32'hFFFF_FFFF, 32'h0000_0001.
- CONF write of 0 and of 17 -> run processes 16 words (o_int 17 edges after start); wr_ptr wraps after 16 writes so the 17th write overwrites in_mem[0].
- During RUN, issue MEM_IN write and a second start -> write dropped, STATUS err = 1, o_int timing unchanged; CTRL 32'h3 after done -> o_int = 0, STATUS = 0.
- Assert reset at RUN cycle 2 of LEN = 8 -> next edge busy = 0, o_int = 0; new start with LEN = 8 completes normally; i_en low for 3 cycles mid-run delays o_int by exactly 3 edges.
